sat_add_scheduler: RTL and testbench

SAT_ADD_SCHEDULER -- requirements
Module: sat_add_scheduler

---
 rtl/sat_add_scheduler.sv | 133 +++++++++++++
 tb/tb_sat_add_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sat_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sat_add_scheduler
// Purpose  : Round-robin arbiter sharing one saturating Q(I.F) adder between
//            N_REQ requesters, with a single-entry result register and a
//            saturation event counter.
// Revision : 1.0
// ============================================================================
module sat_add_scheduler #(
    parameter  int I     = 16,
    parameter  int F     = 16,
    parameter  int N_REQ = 4,
    localparam int W     = I + F,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ-1:0][W-1:0]   req_a_i,
    input  logic [N_REQ-1:0][W-1:0]   req_b_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      rsp_valid_o,
    output logic [W-1:0]              rsp_data_o,
    output logic [IDW-1:0]            rsp_id_o,
    output logic                      rsp_sat_o,
    input  logic                      rsp_ready_i,
    input  logic                      sat_clr_i,
    output logic [15:0]               sat_cnt_o
);

    localparam logic [IDW:0]   c_NREQ = (IDW + 1)'(N_REQ);
    localparam logic [IDW-1:0] c_LAST = IDW'(N_REQ - 1);
    localparam logic [W-1:0]   c_MAX  = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]   c_MIN  = {1'b1, {(W - 1){1'b0}}};

    logic              r_valid;
    logic [W-1:0]      r_data;
    logic [IDW-1:0]    r_id;
    logic              r_sat;
    logic [IDW-1:0]    r_ptr;
    logic [15:0]       r_cnt;

    logic              w_slot_free;
    logic              w_found;
    logic              w_take;
    logic [IDW:0]      w_idx;
    logic [IDW-1:0]    w_gidx;
    logic [W-1:0]      w_a;
    logic [W-1:0]      w_b;
    logic [W-1:0]      w_sum;
    logic              w_ovf;
    logic              w_unf;
    logic              w_clamp;
    logic [W-1:0]      w_res;
    logic [IDW-1:0]    w_ptr_next;

    // Rotating priority search: candidate index wraps back to 0 past N_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_idx = {1'b0, r_ptr} + (IDW + 1)'(off);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (!w_found && req_valid_i[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_idx[IDW-1:0];
            end
        end
    end

    // rst_ni gates the grant so no handshake is advertised while in reset.
    assign w_slot_free = !r_valid || rsp_ready_i;
    assign w_take      = rst_ni && w_slot_free && w_found;

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_take && (w_gidx == IDW'(k))) begin
                req_ready_o[k] = 1'b1;
            end
        end
    end

    assign w_a     = req_a_i[w_gidx];
    assign w_b     = req_b_i[w_gidx];
    assign w_sum   = w_a + w_b;
    assign w_ovf   = !w_a[W-1] && !w_b[W-1] &&  w_sum[W-1];
    assign w_unf   =  w_a[W-1] &&  w_b[W-1] && !w_sum[W-1];
    assign w_clamp = w_ovf || w_unf;
    assign w_res   = w_ovf ? c_MAX : (w_unf ? c_MIN : w_sum);

    assign w_ptr_next = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_sat   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_data  <= w_res;
            r_id    <= w_gidx;
            r_sat   <= w_clamp;
            r_ptr   <= w_ptr_next;
        end else if (rsp_ready_i) begin
            // Drained with nothing new: payload is kept, only valid drops.
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (sat_clr_i) begin
            r_cnt <= '0;
        end else if (w_take && w_clamp && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign rsp_valid_o = r_valid;
    assign rsp_data_o  = r_data;
    assign rsp_id_o    = r_id;
    assign rsp_sat_o   = r_sat;
    assign sat_cnt_o   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sat_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_add_scheduler
// Purpose  : Scoreboard bench for sat_add_scheduler against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_sat_add_scheduler;

    localparam int I = 16;
    localparam int F = 16;
    localparam int N = 4;
    localparam int W = I + F;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0][W-1:0]  req_a;
    logic [N-1:0][W-1:0]  req_b;
    logic [N-1:0]         req_ready;
    logic                 rsp_valid;
    logic [W-1:0]         rsp_data;
    logic [1:0]           rsp_id;
    logic                 rsp_sat;
    logic                 rsp_ready;
    logic                 sat_clr;
    logic [15:0]          sat_cnt;

    typedef struct {
        logic [W-1:0] data;
        int           id;
        logic         sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_ptr;
    bit   m_valid;
    int   m_cnt;

    always #5 clk = ~clk;

    sat_add_scheduler #(.I(I), .F(F), .N_REQ(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .rsp_sat_o   (rsp_sat),
        .rsp_ready_i (rsp_ready),
        .sat_clr_i   (sat_clr),
        .sat_cnt_o   (sat_cnt)
    );

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference: exact signed sum, then clamp to the representable range.
    function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic s);
        longint sa, sb_, sm;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        sm = sa + sb_;
        if (sm > MAXV) begin
            r = W'(MAXV); s = 1'b1;
        end else if (sm < MINV) begin
            r = W'(MINV); s = 1'b1;
        end else begin
            r = W'(sm);   s = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom);
            1:       return {16'h7FFF, 16'($urandom)};
            2:       return {16'h8000, 16'($urandom)};
            default: return 32'($urandom_range(0, 100000));
        endcase
    endfunction

    // Monitor: any presented response must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
            if (rsp_valid && sb.size() != 0) begin
                check("rsp_data", 64'(rsp_data), 64'(sb[0].data));
                check("rsp_id",   64'(rsp_id),   64'(sb[0].id));
                check("rsp_sat",  64'(rsp_sat),  64'(sb[0].sat));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic rdy, input logic clr);
        int           g;
        int           k;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        logic         clamp;
        req_valid = v;
        rsp_ready = rdy;
        sat_clr   = clr;
        clamp     = 1'b0;
        @(negedge clk);
        g = -1;
        if (!m_valid || rdy) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (g < 0 && v[k]) g = k;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("sat_cnt",   64'(sat_cnt),   64'(m_cnt));
        if (g >= 0) begin
            ref_add(req_a[g], req_b[g], e.data, clamp);
            e.id  = g;
            e.sat = clamp;
        end
        @(posedge clk);
        if (g >= 0) begin
            sb.push_back(e);
            m_ptr = (g + 1) % N;
            if (clamp && m_cnt < 65535) m_cnt++;
        end
        if (clr) m_cnt = 0;
        m_valid = (g >= 0) || (m_valid && !rdy);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr   = 0;
        m_valid = 0;
        m_cnt   = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        sat_clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   64'(rsp_valid), 64'd0);
        check("rst_data",    64'(rsp_data),  64'd0);
        check("rst_id",      64'(rsp_id),    64'd0);
        check("rst_sat",     64'(rsp_sat),   64'd0);
        check("rst_cnt",     64'(sat_cnt),   64'd0);
        check("rst_ready",   64'(req_ready), 64'd0);
        rst_n = 1'b1;

        req_a[0] = 32'h0001_0000; req_b[0] = 32'h0002_8000;
        step(4'b0001, 1'b1, 1'b0);
        check("basic_data", 64'(rsp_data), 64'h0003_8000);
        check("basic_id",   64'(rsp_id),   64'd0);
        check("basic_sat",  64'(rsp_sat),  64'd0);
        step(4'b0000, 1'b1, 1'b0);

        req_a[2] = 32'h7FFF_0000; req_b[2] = 32'h0001_0000;
        step(4'b0100, 1'b1, 1'b0);
        check("ovf_data", 64'(rsp_data), 64'h7FFF_FFFF);
        check("ovf_sat",  64'(rsp_sat),  64'd1);
        check("ovf_cnt",  64'(sat_cnt),  64'd1);
        req_a[2] = 32'h8000_0000; req_b[2] = 32'h8000_0000;
        step(4'b0100, 1'b1, 1'b0);
        check("unf_data", 64'(rsp_data), 64'h8000_0000);
        check("unf_sat",  64'(rsp_sat),  64'd1);
        check("unf_cnt",  64'(sat_cnt),  64'd2);
        step(4'b0000, 1'b1, 1'b0);

        // Continuous full load, then backpressure with everyone requesting.
        for (int k = 0; k < N; k++) begin
            req_a[k] = rnd_op(); req_b[k] = rnd_op();
        end
        repeat (8) step(4'hF, 1'b1, 1'b0);
        repeat (5) step(4'hF, 1'b0, 1'b0);
        repeat (4) step(4'hF, 1'b1, 1'b0);

        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                req_a[k] = rnd_op(); req_b[k] = rnd_op();
            end
            step(4'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end

        // Reset while a result is held: it must vanish, priority restarts at 0.
        step(4'hF, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_data",  64'(rsp_data),  64'd0);
        check("mid_rst_id",    64'(rsp_id),    64'd0);
        check("mid_rst_sat",   64'(rsp_sat),   64'd0);
        check("mid_rst_cnt",   64'(sat_cnt),   64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_a[1] = 32'h0000_1234; req_b[1] = 32'hFFFF_0000;
        step(4'b1010, 1'b1, 1'b0);
        check("post_rst_id", 64'(rsp_id), 64'd1);
        step(4'b0000, 1'b1, 1'b0);

        // Counter saturation and clear-over-increment.
        req_a[0] = 32'h7FFF_0000; req_b[0] = 32'h7FFF_0000;
        repeat (65540) step(4'b0001, 1'b1, 1'b0);
        check("cnt_max", 64'(sat_cnt), 64'hFFFF);
        step(4'b0001, 1'b1, 1'b1);
        check("cnt_clr", 64'(sat_cnt), 64'd0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
